// File: rtl/mem_sdp_stream_reader.sv
// Read-side sequencer for a simple dual-port RAM.
// A start pulse latches a block request (start_addr, count). The block walks the RAM read port,
// absorbs the RAM's fixed read latency, and delivers the words as a valid/ready stream with a
// last marker.
//
// Ports:
//   clk, reset_n          - clock and asynchronous active-low reset
//   start                 - one-cycle request pulse, honoured only when idle
//   start_addr, count     - first word address and number of words (0..DEPTH)
//   busy, done            - transfer in progress / one-cycle completion pulse
//   mem_addrb, mem_reb    - RAM read address and read strobe
//   mem_dob               - RAM read data, valid OUTPUT_DELAY cycles after mem_reb
//   m_data, m_valid, m_ready, m_last - output stream
module mem_sdp_stream_reader #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned OUTPUT_DELAY = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] start_addr,
  input  logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] mem_addrb,
  output logic                     mem_reb,
  input  logic [DATA_WIDTH-1:0]    mem_dob,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned FifoDepth = OUTPUT_DELAY + 2;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned PipeW     = (OUTPUT_DELAY == 0) ? 1 : OUTPUT_DELAY;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         rd_addr_q, last_addr_q;
  logic [CW-1:0]         count_q, issued_q, beat_q;
  logic [PipeW-1:0]      tag_q, tag_d;
  logic [DATA_WIDTH-1:0] fifo_q [FifoDepth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]            occ_q;
  logic [2:0]            inflight;
  logic                  issue, push, pop;

  // Every issued read is either a tag in the latency pipe or a word in the FIFO, so
  // occ + inflight is the number of FIFO slots already promised.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(PipeW); i++) begin
      inflight = inflight + 3'(tag_q[i]);
    end
  end

  assign issue = (state_q == StIssue) && ((occ_q + inflight) < 3'(FifoDepth));

  always_comb begin
    tag_d    = tag_q << 1;
    tag_d[0] = issue;
    // With zero latency the word is captured in the issue cycle, so nothing is in flight.
    if (OUTPUT_DELAY == 0) begin
      tag_d = '0;
    end
  end

  assign push    = (OUTPUT_DELAY == 0) ? issue : tag_q[PipeW-1];
  assign m_valid = (occ_q != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = fifo_q[rd_ptr_q];
  assign m_last  = m_valid && (beat_q == (count_q - CW'(1)));

  assign mem_reb   = issue;
  // Present the live address while issuing, otherwise hold the last issued one.
  assign mem_addrb = issue ? rd_addr_q : last_addr_q;
  assign busy      = (state_q == StIssue) || (state_q == StDrain);
  assign done      = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (count == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (issue && ((issued_q + CW'(1)) == count_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      last_addr_q <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      beat_q      <= '0;
      tag_q       <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      if ((state_q == StIdle) && start) begin
        rd_addr_q <= start_addr;
        count_q   <= count;
        issued_q  <= '0;
        beat_q    <= '0;
      end
      if (issue) begin
        rd_addr_q   <= rd_addr_q + AW'(1);
        last_addr_q <= rd_addr_q;
        issued_q    <= issued_q + CW'(1);
      end
      if (pop) begin
        beat_q <= beat_q + CW'(1);
      end
    end
  end

  // First-word-fall-through FIFO; the credit rule on issue keeps it from overflowing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_dob;
        wr_ptr_q <= (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 3'd1;
        2'b01:   occ_q <= occ_q - 3'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sdp_stream_reader.sv
// Bench for mem_sdp_stream_reader: three instances (read latency 0, 1, 2) on a 16-word RAM
// model holding RAM[i] = i + 0x10, driven with a shared request and per-instance ready.
module tb_mem_sdp_stream_reader;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [3:0]      start_addr;
  logic [4:0]      count;
  logic [2:0]      busy, done, mem_reb, m_valid, m_ready, m_last;
  logic [2:0][3:0] mem_addrb;
  logic [2:0][7:0] mem_dob, m_data;

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] ram_val(input logic [3:0] a);
    return {4'h1, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] p1, p2;

    mem_sdp_stream_reader #(
      .DATA_WIDTH  (8),
      .DEPTH       (16),
      .OUTPUT_DELAY(g)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .start_addr(start_addr),
      .count     (count),
      .busy      (busy[g]),
      .done      (done[g]),
      .mem_addrb (mem_addrb[g]),
      .mem_reb   (mem_reb[g]),
      .mem_dob   (mem_dob[g]),
      .m_data    (m_data[g]),
      .m_valid   (m_valid[g]),
      .m_ready   (m_ready[g]),
      .m_last    (m_last[g])
    );

    // RAM read port with a non-stalling pipeline of depth g.
    always_ff @(posedge clk) begin
      p1 <= ram_val(mem_addrb[g]);
      p2 <= p1;
    end
    assign mem_dob[g] = (g == 0) ? ram_val(mem_addrb[g]) : ((g == 1) ? p1 : p2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s L%0d busy", tag, g), int'(busy[g]), 0);
      chk($sformatf("%s L%0d done", tag, g), int'(done[g]), 0);
      chk($sformatf("%s L%0d m_valid", tag, g), int'(m_valid[g]), 0);
      chk($sformatf("%s L%0d m_last", tag, g), int'(m_last[g]), 0);
      chk($sformatf("%s L%0d mem_reb", tag, g), int'(mem_reb[g]), 0);
      chk($sformatf("%s L%0d mem_addrb", tag, g), int'(mem_addrb[g]), 0);
      chk($sformatf("%s L%0d m_data", tag, g), int'(m_data[g]), 0);
    end
  endtask

  // mode 0: ready high; mode 1: 1,0,0,1 pattern with random stalls; mode 2: ready high and a
  // second start pulse in cycle 3 that must be ignored.
  task automatic drive_ready(input int mode, input int k);
    for (int g = 0; g < 3; g++) begin
      if (mode == 1) begin
        m_ready[g] = (((k % 4) == 0) || ((k % 4) == 3)) && ($urandom_range(0, 4) != 0);
      end else begin
        m_ready[g] = 1'b1;
      end
    end
  endtask

  task automatic run_txn(input int id, input int sa, input int cnt, input int mode,
                         input int ef, input int el, input int ed);
    int         iss[3];
    int         pops[3];
    bit         fin[3];
    bit         stall[3];
    logic [7:0] pdata[3];
    logic       plast[3];
    bit         all_fin;
    int         outst;
    bit         exp_reb;
    string      p;
    for (int g = 0; g < 3; g++) begin
      iss[g] = 0; pops[g] = 0; fin[g] = 0; stall[g] = 0; pdata[g] = '0; plast[g] = 1'b0;
    end
    all_fin = 0;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = 4'(sa);
    count      = 5'(cnt);
    drive_ready(mode, 0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!fin[g]) begin
          p = $sformatf("v%0d L%0d c%0d", id, g, k);
          outst   = iss[g] - pops[g];
          exp_reb = (k >= 1) && (iss[g] < cnt) && (outst < g + 2);
          chk({p, " mem_reb"}, int'(mem_reb[g]), int'(exp_reb));
          chk({p, " outstanding"}, int'(outst <= g + 2), 1);
          if (mem_reb[g]) begin
            chk({p, " mem_addrb"}, int'(mem_addrb[g]), (sa + iss[g]) % 16);
          end else if (iss[g] > 0) begin
            chk({p, " addr hold"}, int'(mem_addrb[g]), (sa + iss[g] - 1) % 16);
          end
          if (stall[g]) begin
            chk({p, " stall valid"}, int'(m_valid[g]), 1);
            chk({p, " stall data"}, int'(m_data[g]), int'(pdata[g]));
            chk({p, " stall last"}, int'(m_last[g]), int'(plast[g]));
          end
          if (m_valid[g]) begin
            chk({p, " beat in range"}, int'(pops[g] < cnt), 1);
            chk({p, " m_data"}, int'(m_data[g]), 16 + ((sa + pops[g]) % 16));
            chk({p, " m_last"}, int'(m_last[g]), int'(pops[g] == cnt - 1));
            if (mode != 1) begin
              chk({p, " beat cycle"}, k, pops[g] + g + 2);
            end
            if (m_ready[g]) begin
              if (pops[g] == 0) chk({p, " first beat"}, int'(m_data[g]), ef);
              if (pops[g] == cnt - 1) chk({p, " last beat"}, int'(m_data[g]), el);
              pops[g]++;
            end
          end
          if (mem_reb[g]) iss[g]++;
          if (done[g]) begin
            chk({p, " busy in done"}, int'(busy[g]), 0);
            chk({p, " beats at done"}, pops[g], cnt);
            chk({p, " issues at done"}, iss[g], cnt);
            if (mode != 1) begin
              chk({p, " done cycle"}, k, (cnt == 0) ? ed : ed + g - 1);
            end
            fin[g] = 1;
          end else begin
            chk({p, " busy"}, int'(busy[g]), int'((k >= 1) && (cnt != 0)));
          end
          stall[g] = m_valid[g] && !m_ready[g];
          pdata[g] = m_data[g];
          plast[g] = m_last[g];
        end
      end
      all_fin = fin[0] && fin[1] && fin[2];
      if (all_fin) break;
      @(posedge clk); #1;
      start = 1'b0;
      if ((mode == 2) && (k + 1 == 3)) begin
        start      = 1'b1;
        start_addr = 4'd0;
        count      = 5'd1;
      end
      drive_ready(mode, k + 1);
    end
    if (!all_fin) begin
      chk($sformatf("v%0d completion within budget", id), 0, 1);
    end
    // The block must sit idle afterwards: no restart from the ignored pulse.
    @(posedge clk); #1;
    start = 1'b0;
    drive_ready(0, 0);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("v%0d L%0d idle busy", id, g), int'(busy[g]), 0);
      chk($sformatf("v%0d L%0d idle done", id, g), int'(done[g]), 0);
      chk($sformatf("v%0d L%0d idle valid", id, g), int'(m_valid[g]), 0);
    end
  endtask

  typedef struct {
    int sa;
    int cnt;
    int mode;
    int ef;
    int el;
    int ed;  // done cycle for latency 1 with ready high
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{sa: 3,  cnt: 4,  mode: 0, ef: 'h13, el: 'h16, ed: 7};
    vecs[1] = '{sa: 14, cnt: 4,  mode: 0, ef: 'h1E, el: 'h11, ed: 7};
    vecs[2] = '{sa: 0,  cnt: 8,  mode: 1, ef: 'h10, el: 'h17, ed: 0};
    vecs[3] = '{sa: 9,  cnt: 8,  mode: 1, ef: 'h19, el: 'h10, ed: 0};
    vecs[4] = '{sa: 0,  cnt: 0,  mode: 0, ef: 0,    el: 0,    ed: 1};
    vecs[5] = '{sa: 5,  cnt: 16, mode: 0, ef: 'h15, el: 'h14, ed: 19};
    vecs[6] = '{sa: 5,  cnt: 16, mode: 1, ef: 'h15, el: 'h14, ed: 0};
    vecs[7] = '{sa: 3,  cnt: 4,  mode: 2, ef: 'h13, el: 'h16, ed: 7};

    reset_n    = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    m_ready    = '1;
    #3;
    reset_check("por");
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(i, vecs[i].sa, vecs[i].cnt, vecs[i].mode, vecs[i].ef, vecs[i].el, vecs[i].ed);
    end

    // Reset in the middle of a transfer, then a clean transfer with no stale beats.
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = 4'd2;
    count      = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("pre-reset L%0d busy", g), int'(busy[g]), 1);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    reset_check("mid-reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_txn(8, 6, 4, 0, 'h16, 'h19, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_sdp_stream_reader.md
# mem_sdp_stream_reader

Read-side sequencer for the simple dual-port RAM. On a start pulse it walks a block of RAM words on the RAM's read port (addrb/reb/dob), compensates for the RAM's configured output latency, and presents the words as a valid/ready stream with a last marker. It sits between any RAM filled through the write port (sample buffers, operator/register tables) and a consumer that may stall, such as a DAC/I2S serializer or a debug dump path.

## Interface
Parameters:
- DATA_WIDTH, 8: RAM word width.
- DEPTH, 512: RAM depth in words. Power of two, ≥ 2. AW = $clog2(DEPTH).
- OUTPUT_DELAY, 1: read latency L of the attached RAM. Allowed values are 0, 1 and 2, and must match the RAM instance.

Ports:
- clk, in, 1: single clock for the reader and the RAM read port.
- reset_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle request pulse.
- start_addr, in, AW: first word address.
- count, in, AW+1: number of words to read, 0..DEPTH.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse after the final beat is accepted, or after a zero-length request.
- mem_addrb, out, AW: RAM read address.
- mem_reb, out, 1: RAM read enable and issue strobe.
- mem_dob, in, DATA_WIDTH: RAM read data.
- m_data, out, DATA_WIDTH: stream data.
- m_valid, out, 1: stream valid.
- m_ready, in, 1: stream ready.
- m_last, out, 1: marks the final beat of a request.

## Operation
- States:
  - IDLE: start is accepted here and latched with start_addr and count.
  - ISSUE: reads are issued.
  - DRAIN: all reads are issued; waits for the FIFO to empty and for the last beat to be accepted.
  - DONE: lasts one cycle, drives done=1, then returns to IDLE.
- Transitions:
  - IDLE→ISSUE on start with count≠0.
  - IDLE→DONE on start with count=0. No reads are issued.
  - ISSUE→DRAIN when the issued count reaches count.
  - DRAIN→DONE when the beat with m_last=1 is accepted.
- start outside IDLE is ignored, and no state changes.
- Issue rule: mem_reb=1 in a cycle only when the state is ISSUE and fifo_occ + inflight < FIFO_DEPTH. FIFO_DEPTH = OUTPUT_DELAY+2.
- Issue order:
  - mem_addrb = start_addr + k for the k-th issue, taken modulo DEPTH. The address wraps from DEPTH-1 to 0.
  - mem_addrb holds its value in cycles without an issue.
- Latency pipeline: a shift register of depth L tags each issue. The word on mem_dob is written into the FIFO in cycle t+L, where t is the issue cycle.
  - For L=0, mem_dob is captured in the issue cycle itself.
  - The RAM pipeline never stalls. The credit rule guarantees the FIFO never overflows.
- FIFO: first-word-fall-through.
  - m_valid = !empty, and m_data = head.
  - A pop happens on m_valid && m_ready.
  - Push and pop may occur in the same cycle.
- m_last is 1 when the head is the count-th beat of the request. A per-request beat counter provides this.
- Reset, mid-operation or otherwise: state returns to IDLE, the FIFO is flushed, and inflight tags are cleared. Returned RAM data still in the pipeline is discarded.
- Reset values: busy=0, done=0, m_valid=0, m_last=0, mem_reb=0, mem_addrb=0, m_data=0.
- Widths: the issue and beat counters are AW+1 bits, and the address counter is AW bits (wraps naturally).

## Timing
- Start is sampled in cycle 0.
- busy=1 from cycle 1 until the DONE cycle. busy=0 in the DONE cycle.
- The first mem_reb is in cycle 1.
- The first m_valid is in cycle L+2.
- With m_ready held high, there is one beat per cycle. The last beat is in cycle count+L+1, and done is in the following cycle.
- Zero-length request: done=1 in cycle 1 and busy stays 0.
- Backpressure:
  - Once fifo_occ + inflight reaches FIFO_DEPTH, issues stop.
  - Issues resume the cycle after a pop frees a slot.
  - m_data and m_last stay stable while m_valid && !m_ready.
- A new start is accepted in the cycle after done, and not earlier.

## Test plan
- DEPTH=16, L=1, RAM[i]=i+0x10; start_addr=3, count=4, m_ready=1 -> beats 0x13,0x14,0x15,0x16 in cycles 3..6; m_last only on 0x16; done in cycle 7.
- Wrap-around: start_addr=14, count=4 -> addresses 14,15,0,1 in order; data matches RAM.
- Backpressure, run for each L∈{0,1,2}: count=8 with m_ready toggling 1,0,0,1,... and random stalls -> all 8 beats in order with none lost or duplicated; FIFO occupancy never exceeds L+2; data held stable during stalls.
- count=0 -> done pulse in cycle 1; no mem_reb; m_valid stays 0.
- count=DEPTH=16 from start_addr=5 -> 16 beats covering every address exactly once.
- Interference cases:
  - start pulsed again mid-transfer -> ignored, and the original transfer completes unchanged.
  - reset_n asserted during ISSUE -> all outputs reach reset values immediately; a new start afterwards streams correctly with no stale beats.
